// File: rtl/boot_pkg.sv
// Shared types for the boot sequencer: FSM state encoding, LED status codes, word geometry.
// No logic; constants only.
// Imported by boot_sequencer and byte_assembler.
package boot_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CKSUM,
    ST_FLUSH,
    ST_RUN
  } boot_state_t;

  // One-hot LED codes; CKSUM lights both LOAD and FLUSH LEDs
  localparam logic [3:0] STATUS_IDLE  = 4'b0001;
  localparam logic [3:0] STATUS_LOAD  = 4'b0010;
  localparam logic [3:0] STATUS_CKSUM = 4'b0110;
  localparam logic [3:0] STATUS_FLUSH = 4'b0100;
  localparam logic [3:0] STATUS_RUN   = 4'b1000;

endpackage

// File: rtl/byte_assembler.sv
// Packs UART bytes big-endian into 32-bit words (first byte -> word[31:24]).
// Latency: word/word_valid are combinational in the cycle of the 4th byte.
// No backpressure: every rx_valid byte is taken; clear drops any partial word.
module byte_assembler
  import boot_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  // Hold the first three bytes; counter wraps 3->0 as the word completes
  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (rx_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= {shift_q[15:0], rx_data};
    end
  end

  assign word       = {shift_q, rx_data};
  assign word_valid = rx_valid && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/boot_sequencer.sv
// Owns program load and run control: UART bytes -> imem words from addr 0, then flush, then run.
// Latency: imem write one cycle after the 4th byte; cpu_reset drops FLUSH_CYCLES cycles after FLUSH entry.
// Backpressure: none on UART; optional checksum byte (BOOT_CHECKSUM_EN) is held until tx_ready.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 2,
  parameter int FLUSH_CYCLES   = 5   // must be >= 1
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      load_start,
  input  logic                      load_end,
  input  logic                      tx_ready,
  output logic                      imem_we,
  output logic [INST_MEM_WIDTH-1:0] imem_addr,
  output logic [31:0]               imem_wdata,
  output logic                      cpu_reset,
  output logic                      cpu_run,
  output logic [INST_MEM_WIDTH:0]   word_count,
  output logic                      overflow,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  output logic [3:0]                status
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0]             FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0]             FLUSH_ONE  = FW'(1);
  localparam logic [INST_MEM_WIDTH:0]   MEM_DEPTH  = {1'b1, {INST_MEM_WIDTH{1'b0}}};
  localparam logic [INST_MEM_WIDTH:0]   WC_ONE     = (INST_MEM_WIDTH + 1)'(1);

  boot_state_t   state;
  logic [FW-1:0] flush_cnt;
  logic          byte_acc;
  logic [31:0]   asm_word;
  logic          asm_word_valid;

  // Bytes only count while loading; leaving LOAD drops any partial word
  assign byte_acc = rx_valid && (state == ST_LOAD);

  byte_assembler u_asm (
    .CLK        (CLK),
    .reset      (reset),
    .clear      (state != ST_LOAD),
    .rx_data    (rx_data),
    .rx_valid   (byte_acc),
    .word       (asm_word),
    .word_valid (asm_word_valid)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] cksum;
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign tx_data  = 8'h00;
  assign tx_valid = 1'b0;
`endif

  // Run-control FSM with the write port, counters and status all registered together
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= ST_IDLE;
      status     <= STATUS_IDLE;
      cpu_reset  <= 1'b1;
      cpu_run    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      flush_cnt  <= '0;
`ifdef BOOT_CHECKSUM_EN
      cksum      <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (load_start) begin
            state      <= ST_LOAD;
            status     <= STATUS_LOAD;
            cpu_reset  <= 1'b1;
            cpu_run    <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            cksum      <= '0;
`endif
          end
        end
        ST_LOAD: begin
          // A completed word is written even if load_end arrives in the same cycle
          if (asm_word_valid) begin
            if (word_count == MEM_DEPTH) begin
              overflow <= 1'b1;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= word_count[INST_MEM_WIDTH-1:0];
              imem_wdata <= asm_word;
              word_count <= word_count + WC_ONE;
            end
          end
`ifdef BOOT_CHECKSUM_EN
          if (byte_acc) begin
            cksum <= cksum + rx_data;
          end
`endif
          if (load_end) begin
`ifdef BOOT_CHECKSUM_EN
            state    <= ST_CKSUM;
            status   <= STATUS_CKSUM;
            tx_valid <= 1'b1;
            tx_data  <= byte_acc ? cksum + rx_data : cksum;
`else
            state     <= ST_FLUSH;
            status    <= STATUS_FLUSH;
            flush_cnt <= '0;
`endif
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CKSUM: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            state     <= ST_FLUSH;
            status    <= STATUS_FLUSH;
            flush_cnt <= '0;
          end
        end
`endif
        ST_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state     <= ST_RUN;
            status    <= STATUS_RUN;
            cpu_reset <= 1'b0;
            cpu_run   <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FLUSH_ONE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          status    <= STATUS_IDLE;
          cpu_reset <= 1'b1;
          cpu_run   <= 1'b0;
        end
      endcase
    end
  end

endmodule
